// File: rtl/gray2rgb_pkg.sv
// Shared types and defaults for the gray-to-RGB pseudo-color pipeline.
package gray2rgb_pkg;

  localparam int unsigned DefImgWidth  = 640;
  localparam int unsigned DefImgHeight = 480;

  typedef logic [7:0] pixel_t;

  // Top two intensity bits pick one of four hue ramps.
  typedef enum logic [1:0] {
    SegBlueCyan    = 2'd0,
    SegCyanGreen   = 2'd1,
    SegGreenYellow = 2'd2,
    SegYellowRed   = 2'd3
  } seg_e;

endpackage

// File: rtl/gray2rgb_colormap.sv
// Combinational four-segment colormap: segment + 8-bit fraction to R/G/B.
// Only compiled when GRAY2RGB_PSEUDO_COLOR_EN is defined.
`ifdef GRAY2RGB_PSEUDO_COLOR_EN
module gray2rgb_colormap
  import gray2rgb_pkg::*;
(
  input  seg_e   s,
  input  pixel_t f,
  output pixel_t R,
  output pixel_t G,
  output pixel_t B
);

  // Piecewise-linear ramp; f tops out at 252 so 255-f cannot underflow.
  always_comb begin
    R = '0;
    G = '0;
    B = '0;
    unique case (s)
      SegBlueCyan: begin
        R = 8'd0;
        G = f;
        B = 8'd255;
      end
      SegCyanGreen: begin
        R = 8'd0;
        G = 8'd255;
        B = 8'd255 - f;
      end
      SegGreenYellow: begin
        R = f;
        G = 8'd255;
        B = 8'd0;
      end
      SegYellowRed: begin
        R = 8'd255;
        G = 8'd255 - f;
        B = 8'd0;
      end
    endcase
  end

endmodule
`endif

// File: rtl/gray2rgb_pseudo.sv
// Two-stage streaming gray-to-RGB converter with line/frame position flags.
// Define GRAY2RGB_PSEUDO_COLOR_EN for the pseudo-color map; otherwise the
// output is neutral gray (R=G=B=input) with identical timing.
module gray2rgb_pseudo
  import gray2rgb_pkg::*;
#(
  parameter int unsigned IMG_WIDTH  = DefImgWidth,
  parameter int unsigned IMG_HEIGHT = DefImgHeight
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] grayscale,
  input  logic       Valid_in,
  output logic       Ready_in,
  output logic [7:0] R,
  output logic [7:0] G,
  output logic [7:0] B,
  output logic       Valid_out,
  input  logic       Ready_out,
  output logic       End_line,
  output logic       End_frame
);

  localparam int unsigned ColW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam int unsigned RowW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam logic [ColW-1:0] ColLast = ColW'(IMG_WIDTH - 1);
  localparam logic [RowW-1:0] RowLast = RowW'(IMG_HEIGHT - 1);

  logic   en;
  logic   valid1_q, valid2_q;
  pixel_t r_map, g_map, b_map;
  pixel_t r_q, g_q, b_q;

  // Whole pipeline stalls only when the output holds a pixel nobody takes.
  assign en       = !(valid2_q && !Ready_out);
  assign Ready_in = en && !rst;

`ifdef GRAY2RGB_PSEUDO_COLOR_EN
  seg_e   seg1_q;
  pixel_t frac1_q;

  // Stage 1: capture segment and fraction of the accepted pixel.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid1_q <= 1'b0;
      seg1_q   <= SegBlueCyan;
      frac1_q  <= '0;
    end else if (en) begin
      valid1_q <= Valid_in;
      if (Valid_in) begin
        seg1_q  <= seg_e'(grayscale[7:6]);
        frac1_q <= {grayscale[5:0], 2'b00};
      end
    end
  end

  gray2rgb_colormap u_colormap (
    .s (seg1_q),
    .f (frac1_q),
    .R (r_map),
    .G (g_map),
    .B (b_map)
  );
`else
  pixel_t pix1_q;

  // Stage 1: capture the accepted pixel.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid1_q <= 1'b0;
      pix1_q   <= '0;
    end else if (en) begin
      valid1_q <= Valid_in;
      if (Valid_in) begin
        pix1_q <= grayscale;
      end
    end
  end

  assign r_map = pix1_q;
  assign g_map = pix1_q;
  assign b_map = pix1_q;
`endif

  // Stage 2: register the color; data only moves when stage 1 holds a pixel.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid2_q <= 1'b0;
      r_q      <= '0;
      g_q      <= '0;
      b_q      <= '0;
    end else if (en) begin
      valid2_q <= valid1_q;
      if (valid1_q) begin
        r_q <= r_map;
        g_q <= g_map;
        b_q <= b_map;
      end
    end
  end

  logic [ColW-1:0] col_q, col_d;
  logic [RowW-1:0] row_q, row_d;
  logic            out_xfer;

  assign out_xfer = valid2_q && Ready_out;

  // Position counters advance once per output transfer, wrapping per line/frame.
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (out_xfer) begin
      if (col_q == ColLast) begin
        col_d = '0;
        row_d = (row_q == RowLast) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  // Position counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  assign Valid_out = valid2_q;
  assign R         = r_q;
  assign G         = g_q;
  assign B         = b_q;
  assign End_line  = valid2_q && (col_q == ColLast);
  assign End_frame = End_line && (row_q == RowLast);

endmodule

// File: tb/tb_gray2rgb_pseudo.sv
// Self-checking bench for gray2rgb_pseudo (IMG_WIDTH=4, IMG_HEIGHT=2).
// Expected colors follow GRAY2RGB_PSEUDO_COLOR_EN the same way as the design.
module tb_gray2rgb_pseudo;

  localparam int W = 4;
  localparam int H = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] grayscale = 8'd0;
  logic       Valid_in = 1'b0;
  logic       Ready_out = 1'b1;
  logic       Ready_in;
  logic [7:0] R, G, B;
  logic       Valid_out, End_line, End_frame;

  int n_checks = 0;
  int n_errors = 0;
  int mcol = 0;
  int mrow = 0;

  gray2rgb_pseudo #(
    .IMG_WIDTH  (W),
    .IMG_HEIGHT (H)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .grayscale (grayscale),
    .Valid_in  (Valid_in),
    .Ready_in  (Ready_in),
    .R         (R),
    .G         (G),
    .B         (B),
    .Valid_out (Valid_out),
    .Ready_out (Ready_out),
    .End_line  (End_line),
    .End_frame (End_frame)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  gray;
    logic [23:0] rgb;
    logic        eol;
    logic        eof;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [23:0] exp_rgb(input logic [7:0] g);
`ifdef GRAY2RGB_PSEUDO_COLOR_EN
    logic [7:0] f;
    f = {g[5:0], 2'b00};
    case (g[7:6])
      2'd0:    return {8'd0, f, 8'd255};
      2'd1:    return {8'd0, 8'd255, 8'd255 - f};
      2'd2:    return {f, 8'd255, 8'd0};
      default: return {8'd255, 8'd255 - f, 8'd0};
    endcase
`else
    return {g, g, g};
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Streams n pixels in order, optionally holding Ready_out low for a window,
  // and checks every output transfer against the model and the position model.
  task automatic run_stream(input int n, input logic [7:0] base, input int st0,
                            input int stlen);
    int          sent;
    int          recv;
    logic [26:0] snap;
    logic [23:0] e;
    logic        eol_e;
    logic        eof_e;
    sent = 0;
    recv = 0;
    snap = '0;
    for (int cyc = 0; cyc < n + stlen + 20; cyc++) begin
      if (recv >= n) break;
      Ready_out = !(cyc >= st0 && cyc < st0 + stlen);
      Valid_in  = (sent < n);
      grayscale = base + 8'(sent * 37);
      #1;
      if (!Ready_out && Valid_out) begin
        chk("stall_ready_in", {31'd0, Ready_in}, 32'd0);
        if (cyc == st0) snap = {R, G, B, Valid_out, End_line, End_frame};
        else chk("stall_frozen", {5'd0, R, G, B, Valid_out, End_line, End_frame}, {5'd0, snap});
      end
      if (Valid_out && Ready_out) begin
        e     = exp_rgb(base + 8'(recv * 37));
        eol_e = (mcol == W - 1);
        eof_e = eol_e && (mrow == H - 1);
        chk("stream_rgb", {8'd0, R, G, B}, {8'd0, e});
        chk("stream_eol_eof", {30'd0, End_line, End_frame}, {30'd0, eol_e, eof_e});
        if (mcol == W - 1) begin
          mcol = 0;
          mrow = (mrow == H - 1) ? 0 : mrow + 1;
        end else begin
          mcol++;
        end
        recv++;
      end
      if (Valid_in && Ready_in) sent++;
      step();
    end
    Valid_in  = 1'b0;
    Ready_out = 1'b1;
    chk("stream_count", recv, n);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
`ifdef GRAY2RGB_PSEUDO_COLOR_EN
    tbl[0] = '{8'd0,   24'h0000FF, 1'b0, 1'b0};
    tbl[1] = '{8'd64,  24'h00FFFF, 1'b0, 1'b0};
    tbl[2] = '{8'd128, 24'h00FF00, 1'b0, 1'b0};
    tbl[3] = '{8'd192, 24'hFFFF00, 1'b1, 1'b0};
    tbl[4] = '{8'd255, 24'hFF0300, 1'b0, 1'b0};
    tbl[5] = '{8'h5A,  24'h00FF97, 1'b0, 1'b0};
    tbl[6] = '{8'd7,   24'h001CFF, 1'b0, 1'b0};
    tbl[7] = '{8'd200, 24'hFFDF00, 1'b1, 1'b1};
`else
    tbl[0] = '{8'd0,   24'h000000, 1'b0, 1'b0};
    tbl[1] = '{8'd64,  24'h404040, 1'b0, 1'b0};
    tbl[2] = '{8'd128, 24'h808080, 1'b0, 1'b0};
    tbl[3] = '{8'd192, 24'hC0C0C0, 1'b1, 1'b0};
    tbl[4] = '{8'd255, 24'hFFFFFF, 1'b0, 1'b0};
    tbl[5] = '{8'h5A,  24'h5A5A5A, 1'b0, 1'b0};
    tbl[6] = '{8'd7,   24'h070707, 1'b0, 1'b0};
    tbl[7] = '{8'd200, 24'hC8C8C8, 1'b1, 1'b1};
`endif

    // Reset state, held over several edges.
    rst       = 1'b1;
    Valid_in  = 1'b1;
    grayscale = 8'hAA;
    repeat (3) step();
    chk("reset_valid_out", {31'd0, Valid_out}, 32'd0);
    chk("reset_rgb", {8'd0, R, G, B}, 32'd0);
    chk("reset_flags", {30'd0, End_line, End_frame}, 32'd0);
    chk("reset_ready_in", {31'd0, Ready_in}, 32'd0);
    rst      = 1'b0;
    Valid_in = 1'b0;
    #1;
    chk("ready_after_reset", {31'd0, Ready_in}, 32'd1);

    // Two full frames back-to-back; output k shows input k-2.
    for (int k = 0; k < 18; k++) begin
      Ready_out = 1'b1;
      Valid_in  = (k < 16);
      grayscale = tbl[k % 8].gray;
      #1;
      chk("table_ready_in", {31'd0, Ready_in}, 32'd1);
      if (k >= 2) begin
        chk("table_valid_out", {31'd0, Valid_out}, 32'd1);
        chk("table_rgb", {8'd0, R, G, B}, {8'd0, tbl[(k - 2) % 8].rgb});
        chk("table_flags", {30'd0, End_line, End_frame},
            {30'd0, tbl[(k - 2) % 8].eol, tbl[(k - 2) % 8].eof});
      end
      step();
    end
    chk("table_drained", {31'd0, Valid_out}, 32'd0);
    mcol = 0;
    mrow = 0;

    // Continuous input with a 5-cycle downstream stall while an End_line pixel waits.
    run_stream(12, 8'h10, 5, 5);

    // Move mid-line, then reset with two pixels in flight.
    run_stream(2, 8'h01, 0, 0);
    Ready_out = 1'b1;
    Valid_in  = 1'b1;
    grayscale = 8'h11;
    step();
    grayscale = 8'h22;
    step();
    Valid_in  = 1'b0;
    Ready_out = 1'b0;
    rst       = 1'b1;
    #1;
    chk("midrst_ready_in", {31'd0, Ready_in}, 32'd0);
    step();
    chk("midrst_valid_out", {31'd0, Valid_out}, 32'd0);
    chk("midrst_rgb", {8'd0, R, G, B}, 32'd0);
    chk("midrst_flags", {30'd0, End_line, End_frame}, 32'd0);
    rst       = 1'b0;
    Ready_out = 1'b1;
    #1;
    chk("midrst_ready_after", {31'd0, Ready_in}, 32'd1);
    mcol = 0;
    mrow = 0;
    run_stream(4, 8'h33, 0, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/gray2rgb_pseudo.md
GRAY2RGB_PSEUDO -- requirements
Module: gray2rgb_pseudo

Interface
REQ-001 Parameter IMG_WIDTH, default 640, pixels per line (>=2).
REQ-002 Parameter IMG_HEIGHT, default 480, lines per frame (>=2).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 grayscale  input  8  input pixel intensity, unsigned.
REQ-006 Valid_in  input  1  grayscale carries a pixel this cycle.
REQ-007 Ready_in  output  1  block accepts the input pixel this cycle.
REQ-008 R, G, B  output  8 each  output color pixel, unsigned.
REQ-009 Valid_out  output  1  R/G/B carry a pixel this cycle.
REQ-010 Ready_out  input  1  downstream accepts the output pixel this cycle.
REQ-011 End_line  output  1  high with Valid_out on the last pixel of a line.
REQ-012 End_frame  output  1  high with Valid_out on the last pixel of a frame.

Function
REQ-013 Input transfer occurs when Valid_in & Ready_in, and output transfer occurs when Valid_out & Ready_out.
REQ-014 Two-stage pipeline: stage 1 registers the pixel and its segment/fraction, stage 2 registers R/G/B, giving 2-cycle latency when unstalled.
REQ-015 Global advance enable en = !(Valid_out & !Ready_out); Ready_in = en & !rst, combinational.
REQ-016 When en is low, both stages and all outputs hold their values and no input is consumed.
REQ-017 Valid bits shift with en; a stage whose predecessor holds no pixel loads valid=0 and leaves its data unchanged.
REQ-018 Full throughput of one pixel per cycle with Ready_out held high; no bubble is inserted on a stall release.
REQ-019 Segment s = grayscale[7:6], fraction f = {grayscale[5:0],2'b00} (0..252).
REQ-020 s=0: R=0, G=f, B=255. s=1: R=0, G=255, B=255-f. s=2: R=f, G=255, B=0. s=3: R=255, G=255-f, B=0.
REQ-021 All arithmetic is 8-bit unsigned; 255-f never underflows, and no saturation logic exists.
REQ-022 Column counter (0..IMG_WIDTH-1) and row counter (0..IMG_HEIGHT-1) advance only on output transfer.
REQ-023 End_line = Valid_out & (col==IMG_WIDTH-1); End_frame = End_line & (row==IMG_HEIGHT-1).
REQ-024 On output transfer at col==IMG_WIDTH-1, col wraps to 0 and row increments; at the frame end, row also wraps to 0.
REQ-025 End_line and End_frame hold steady during a stall, together with their pixel.
REQ-026 Pixels are never dropped or duplicated: output order equals input order.

Reset
REQ-027 While rst is high: Valid_out=0, R=G=B=0, End_line=End_frame=0, Ready_in=0, and both stage valid bits and both counters are 0.
REQ-028 Reset mid-frame discards in-flight pixels, and the first pixel transferred after reset is col 0, row 0.
REQ-029 Ready_in is 1 in the first cycle after rst deasserts.

Configuration
REQ-030 Macro GRAY2RGB_PSEUDO_COLOR_EN defined: colormap per REQ-020.
REQ-031 Macro absent: R=G=B=grayscale (neutral gray), with identical latency, handshake, and counters; colormap logic is not compiled.

Structure
REQ-032 Package gray2rgb_pkg: segment encodings, the default IMG_WIDTH/IMG_HEIGHT values, and an 8-bit pixel typedef.
REQ-033 One combinational sub-module, gray2rgb_colormap (s, f in; R, G, B out), is instantiated between stages 1 and 2; it is omitted when the macro is absent.

Verification
REQ-034 Macro on, Ready_out=1, inputs 0, 64, 128, 192, 255 back-to-back -> outputs 2 cycles later (0,0,255), (0,255,255), (0,255,0), (255,255,0), (255,3,0).
REQ-035 Macro off, input 0x5A -> R=G=B=0x5A after 2 cycles.
REQ-036 Continuous Valid_in, Ready_out low for 5 cycles mid-stream -> Ready_in low for those cycles, outputs frozen, and the sequence resumes with no loss or duplication.
REQ-037 IMG_WIDTH=4, IMG_HEIGHT=2, 8 pixels then 8 more -> End_line on pixels 4 and 8, End_frame on pixel 8, and identical pattern in the second frame.
REQ-038 rst asserted for 1 cycle with 2 pixels in flight -> those pixels never appear, and the next pixel is flagged col 0 with End_line after 4 pixels (IMG_WIDTH=4).
